b_bop_arb: RTL and testbench
============================

B_BOP_ARB -- requirements
Module: b_bop_arb

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clock  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_rd, req0_rs1, req0_rs2  in  32 each  requester 0 operands.
REQ-007 req0_lut  in  8  requester 0 3-input truth table.
REQ-008 req1_valid, req1_ready, req1_rd, req1_rs1, req1_rs2, req1_lut  SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 rsp_valid  out  1  response register holds a result.
REQ-010 rsp_ready  in  1  consumer takes the response this cycle when high with rsp_valid.
REQ-011 rsp_result  out  32  registered bop result.
REQ-012 rsp_id  out  1  requester that issued the held result (0 or 1).

Function
REQ-013 The block SHALL instantiate exactly one b_bop datapath (ports rd, rs1, rs2, lut, result), shared between both requesters through an operand multiplexer driven by the grant.
REQ-014 Per bit i: result[i] = lut[{rd[i], rs2[i], rs1[i]}].
REQ-015 State: EMPTY (rsp_valid=0) or FULL (rsp_valid=1); one 32-bit result register, one id bit, one last_grant bit.
REQ-016 slot_free = EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-017 Grant: only one valid requester -> that requester; both valid -> arbitration per REQ-029/REQ-030; none -> no grant.
REQ-018 reqN_ready SHALL be 1 only for the granted requester and only when slot_free; the non-granted ready SHALL be 0.
REQ-019 reqN_ready SHALL NOT depend combinationally on rsp_result or on the other requester's operands.
REQ-020 Accept (valid and ready high for the granted requester) at cycle N: rsp_result/rsp_id load at edge N+1; rsp_valid=1 from cycle N+1. Latency is 1 cycle.
REQ-021 Throughput: a drain and an accept in the same cycle SHALL keep FULL and load the new result, with no bubble.
REQ-022 Drain with no accept: FULL -> EMPTY.
REQ-023 FULL with rsp_ready=0: rsp_result and rsp_id SHALL hold stable and both readies SHALL be 0.
REQ-024 rsp_result and rsp_id in EMPTY SHALL hold their last value (don't-care to consumers).
REQ-025 last_grant SHALL update to the accepted requester's id on every accept, and only on accept.
REQ-026 Requesters may drop valid without a handshake; the arbiter SHALL NOT latch or assume pending operands.

Reset
REQ-027 While reset=1: rsp_valid=0, rsp_result=0, rsp_id=0, last_grant=1, both readies=0; any held response is discarded.
REQ-028 The first cycle after reset deasserts SHALL accept operations normally.

Configuration
REQ-029 With macro B_BOP_ARB_RR_EN defined: on contention the grant SHALL go to the requester != last_grant (round-robin; requester 0 wins the first contention after reset).
REQ-030 Without B_BOP_ARB_RR_EN: on contention requester 0 SHALL always win (fixed priority); last_grant is still maintained but unused.

Verification
REQ-031 Req0 alone: rd=0xF0F0F0F0, rs1=0xFF00FF00, rs2=0xAAAAAAAA, lut=0x96, rsp_ready=1 -> next cycle rsp_valid=1, rsp_result=0xA55AA55A, rsp_id=0.
REQ-032 Both valid for 4 cycles, rsp_ready=1, with RR_EN -> rsp_id sequence 0,1,0,1; without RR_EN -> 0,0,0,0.
REQ-033 Back-pressure: rsp_ready=0 for 3 cycles while FULL -> rsp_result stable, req0_ready=req1_ready=0; rsp_ready=1 -> drain plus a new accept in the same cycle, rsp_valid stays 1.
REQ-034 Req1 alone: all operands 0xFFFFFFFF, lut=0x80 -> rsp_result=0xFFFFFFFF, rsp_id=1; with lut=0x7F -> 0x00000000.
REQ-035 Reset asserted while FULL and rsp_ready=0 -> next cycle rsp_valid=0, rsp_result=0; after release, the first contention is granted to requester 0.
REQ-036 A formal property SHALL assert that every loaded rsp_result equals the REQ-014 function of the accepted requester's operands, for arbitrary operand and lut values.

Source files
------------

// File: rtl/b_bop_arb.sv
// Two-requester arbiter sharing one 3-input bitwise LUT datapath, 1-cycle latency, single response slot.
// Readies drop while the slot is full and not being drained. Define B_BOP_ARB_RR_EN for round-robin on contention.

module b_bop (
    input  logic [31:0] rd,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [7:0]  lut,
    output logic [31:0] result
);
    always_comb begin
        result = '0;
        for (int i = 0; i < 32; i++) begin
            result[i] = lut[{rd[i], rs2[i], rs1[i]}];
        end
    end
endmodule

module b_bop_arb (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_rd,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [7:0]  req0_lut,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_rd,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [7:0]  req1_lut,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_id
);
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic        rsp_id_q, rsp_id_d;
    logic        last_grant_q, last_grant_d;

    logic        contend_gnt;
    logic        gnt_vld;
    logic        gnt_id;
    logic        slot_free;
    logic        accept;
    logic [31:0] mux_rd, mux_rs1, mux_rs2;
    logic [7:0]  mux_lut;
    logic [31:0] bop_result;

    always_comb begin
`ifdef B_BOP_ARB_RR_EN
        contend_gnt = ~last_grant_q;
`else
        contend_gnt = 1'b0;
`endif
        gnt_vld   = req0_valid | req1_valid;
        gnt_id    = (req0_valid & req1_valid) ? contend_gnt : req1_valid;
        slot_free = ~rsp_valid_q | rsp_ready;
        // Reset gating keeps both readies low while reset is held.
        accept     = gnt_vld & slot_free & ~reset;
        req0_ready = accept & ~gnt_id;
        req1_ready = accept & gnt_id;
    end

    always_comb begin
        mux_rd  = gnt_id ? req1_rd  : req0_rd;
        mux_rs1 = gnt_id ? req1_rs1 : req0_rs1;
        mux_rs2 = gnt_id ? req1_rs2 : req0_rs2;
        mux_lut = gnt_id ? req1_lut : req0_lut;
    end

    b_bop u_bop (
        .rd     (mux_rd),
        .rs1    (mux_rs1),
        .rs2    (mux_rs2),
        .lut    (mux_lut),
        .result (bop_result)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = bop_result;
            rsp_id_d     = gnt_id;
            last_grant_d = gnt_id;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_id     = rsp_id_q;

`ifndef SYNTHESIS
    // Independent reference of the LUT function over the muxed operands.
    logic [31:0] ref_result;
    always_comb begin
        ref_result = '0;
        for (int i = 0; i < 32; i++) begin
            ref_result[i] = mux_lut[(mux_rd[i] ? 4 : 0) + (mux_rs2[i] ? 2 : 0) + (mux_rs1[i] ? 1 : 0)];
        end
    end

    a_result_matches: assert property (@(posedge clock) disable iff (reset)
        accept |=> (rsp_result_q == $past(ref_result)));

    a_last_grant_tracks: assert property (@(posedge clock) disable iff (reset)
        accept |=> (last_grant_q == rsp_id_q));
`endif
endmodule

// File: tb/tb_b_bop_arb.sv
// Randomised plus directed bench for b_bop_arb against a cycle-level behavioural model.
module tb_b_bop_arb;
    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_rd, req0_rs1, req0_rs2, req1_rd, req1_rs1, req1_rs2;
    logic [7:0]  req0_lut, req1_lut;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;

    int n_checks = 0;
    int n_err    = 0;

`ifdef B_BOP_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    b_bop_arb dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_rd(req0_rd), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_lut(req0_lut),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_rd(req1_rd), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_lut(req1_lut),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bop(input logic [31:0] rd, input logic [31:0] rs1,
                                        input logic [31:0] rs2, input logic [7:0] lut);
        logic [31:0] r;
        int idx;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            idx  = (rd[i] ? 4 : 0) + (rs2[i] ? 2 : 0) + (rs1[i] ? 1 : 0);
            r[i] = lut[idx];
        end
        return r;
    endfunction

    // Behavioural model: one response slot, plus who won last.
    bit          m_init = 1'b0;
    bit          m_valid;
    logic [31:0] m_result;
    bit          m_id;
    bit          m_last;

    always @(negedge clock) begin
        int w;
        bit free, e0, e1;
        if (!req0_valid && !req1_valid) w = -1;
        else if (req0_valid && !req1_valid) w = 0;
        else if (!req0_valid) w = 1;
        else w = (RR && m_last == 1'b0) ? 1 : 0;
        free = !m_valid || rsp_ready;
        e0 = !reset && free && (w == 0);
        e1 = !reset && free && (w == 1);
        if (m_init) begin
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_valid});
            chk("rsp_result", rsp_result, m_result);
            chk("rsp_id", {31'b0, rsp_id}, {31'b0, m_id});
            chk("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
            chk("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
        end
        if (reset) begin
            m_init = 1'b1; m_valid = 1'b0; m_result = '0; m_id = 1'b0; m_last = 1'b1;
        end else if (m_init) begin
            if (e0 || e1) begin
                m_result = e1 ? bop(req1_rd, req1_rs1, req1_rs2, req1_lut)
                              : bop(req0_rd, req0_rs1, req0_rs2, req0_lut);
                m_valid = 1'b1;
                m_id    = e1;
                m_last  = e1;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set0(input logic v, input logic [31:0] rd, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [7:0] lut);
        req0_valid = v; req0_rd = rd; req0_rs1 = rs1; req0_rs2 = rs2; req0_lut = lut;
    endtask

    task automatic set1(input logic v, input logic [31:0] rd, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [7:0] lut);
        req1_valid = v; req1_rd = rd; req1_rs1 = rs1; req1_rs2 = rs2; req1_lut = lut;
    endtask

    initial begin
        logic [31:0] held;
        bit exp_id [4];
        reset = 1'b1;
        rsp_ready = 1'b0;
        set0(1'b1, 32'h0, 32'h0, 32'h0, 8'h0);
        set1(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
        step(); step();
        @(negedge clock);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset rsp_result", rsp_result, 32'd0);
        chk("reset rsp_id", {31'b0, rsp_id}, 32'd0);
        chk("reset req0_ready", {31'b0, req0_ready}, 32'd0);

        // Lone requester 0, first cycle out of reset.
        step();
        reset = 1'b0; rsp_ready = 1'b1;
        set0(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hAAAAAAAA, 8'h96);
        @(negedge clock);
        chk("first req0_ready", {31'b0, req0_ready}, 32'd1);
        chk("first req1_ready", {31'b0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        @(negedge clock);
        chk("xor3 valid", {31'b0, rsp_valid}, 32'd1);
        chk("xor3 result", rsp_result, 32'hA55AA55A);
        chk("xor3 id", {31'b0, rsp_id}, 32'd0);

        // Lone requester 1: AND3 then NAND3 on all-ones.
        step();
        set1(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h80);
        step();
        req1_lut = 8'h7F;
        @(negedge clock);
        chk("and3 result", rsp_result, 32'hFFFFFFFF);
        chk("and3 id", {31'b0, rsp_id}, 32'd1);
        step();
        req1_valid = 1'b0;
        @(negedge clock);
        chk("nand3 result", rsp_result, 32'h00000000);
        chk("nand3 id", {31'b0, rsp_id}, 32'd1);

        // Contention for four cycles.
        step();
        set0(1'b1, $urandom, $urandom, $urandom, 8'($urandom));
        set1(1'b1, $urandom, $urandom, $urandom, 8'($urandom));
        exp_id = RR ? '{1'b0, 1'b1, 1'b0, 1'b1} : '{1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            step();
            @(negedge clock);
            chk($sformatf("contend id[%0d]", k), {31'b0, rsp_id}, {31'b0, exp_id[k]});
        end

        // Back-pressure while full.
        step();
        rsp_ready = 1'b0;
        @(negedge clock);
        held = rsp_result;
        for (int k = 0; k < 3; k++) begin
            chk("bp req0_ready", {31'b0, req0_ready}, 32'd0);
            chk("bp req1_ready", {31'b0, req1_ready}, 32'd0);
            chk("bp result stable", rsp_result, held);
            step();
            @(negedge clock);
        end
        step();
        rsp_ready = 1'b1; req1_valid = 1'b0;
        set0(1'b1, 32'h0, 32'h0000FFFF, 32'h0, 8'h02);
        @(negedge clock);
        chk("drain+accept req0_ready", {31'b0, req0_ready}, 32'd1);
        step();
        @(negedge clock);
        chk("drain+accept valid", {31'b0, rsp_valid}, 32'd1);
        chk("drain+accept result", rsp_result, 32'h0000FFFF);

        // Reset while full and stalled.
        step();
        rsp_ready = 1'b0; reset = 1'b1;
        req0_valid = 1'b0;
        step();
        @(negedge clock);
        chk("rst full valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst full result", rsp_result, 32'd0);
        step();
        reset = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        step();
        @(negedge clock);
        chk("post-reset contention id", {31'b0, rsp_id}, 32'd0);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            step();
            reset     = ($urandom_range(0, 99) == 0);
            rsp_ready = ($urandom_range(0, 1) == 1);
            set0($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom, 8'($urandom));
            set1($urandom_range(0, 9) < 6, $urandom, $urandom, $urandom, 8'($urandom));
        end
        step();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
